// File: rtl/eth_tx_sf_buffer.sv
// eth_tx_sf_buffer: store-and-forward frame buffer ahead of the GMII transmitter.
// A frame is released to the output only after its last byte is stored, so
// m_axis_tvalid never drops mid-frame. Bad frames and frames that overflow the
// buffer are rolled back and reported on one-cycle status pulses.
// Optional feature macro: ETH_TX_SF_FRAME_COUNT_EN adds status_frame_count.
module eth_tx_sf_buffer #(
    parameter int DEPTH          = 4096,
    parameter int DATA_WIDTH     = 8,
    parameter int USER_WIDTH     = 1,
    parameter int DROP_BAD_FRAME = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    input  logic [USER_WIDTH-1:0]     s_axis_tuser,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic [USER_WIDTH-1:0]     m_axis_tuser,
    output logic                      status_overflow,
    output logic                      status_bad_frame,
    output logic                      status_good_frame
`ifdef ETH_TX_SF_FRAME_COUNT_EN
    ,
    output logic [$clog2(DEPTH):0]    status_frame_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = USER_WIDTH + 1 + DATA_WIDTH;
    localparam logic [AW:0] PTR_ONE   = 1;
    localparam logic [AW:0] PTR_DEPTH = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_DROP} wr_state_t;

    wr_state_t state, state_nxt;

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] mem_rd_q;
    logic          mem_rd_vld;

    logic [AW:0] wr_ptr_cur, wr_ptr_commit, rd_ptr, fill;
    logic        full, empty, accept;
    logic        mem_we, drop_ovf, drop_bad, commit;
    logic        out_ready, rd_en;

    assign accept = s_axis_tvalid & s_axis_tready;
    assign fill   = wr_ptr_cur - rd_ptr;
    assign full   = (fill == PTR_DEPTH);
    assign empty  = (rd_ptr == wr_ptr_commit);

    // Output register can take a new beat when empty or being consumed; the
    // RAM read stage refills whenever it is empty or hands its beat forward.
    assign out_ready = !m_axis_tvalid || m_axis_tready;
    assign rd_en     = !empty && (!mem_rd_vld || out_ready);

    // Write-side state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WR_IDLE;
        else     state <= state_nxt;
    end

    // Write-side next state and per-beat actions (store, commit, roll back)
    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        drop_ovf  = 1'b0;
        drop_bad  = 1'b0;
        commit    = 1'b0;
        if (accept) begin
            case (state)
                WR_IDLE, WR_DATA: begin
                    if (full) begin
                        // A full beat that is also tlast has no tail left to discard.
                        drop_ovf  = 1'b1;
                        state_nxt = s_axis_tlast ? WR_IDLE : WR_DROP;
                    end else begin
                        mem_we = 1'b1;
                        if (s_axis_tlast) begin
                            state_nxt = WR_IDLE;
                            if (DROP_BAD_FRAME != 0 && s_axis_tuser[0]) drop_bad = 1'b1;
                            else                                         commit   = 1'b1;
                        end else begin
                            state_nxt = WR_DATA;
                        end
                    end
                end
                WR_DROP: if (s_axis_tlast) state_nxt = WR_IDLE;
                default: state_nxt = WR_IDLE;
            endcase
        end
    end

    // Write pointers, input ready and status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_cur        <= '0;
            wr_ptr_commit     <= '0;
            s_axis_tready     <= 1'b0;
            status_overflow   <= 1'b0;
            status_bad_frame  <= 1'b0;
            status_good_frame <= 1'b0;
        end else begin
            s_axis_tready     <= 1'b1;
            status_overflow   <= drop_ovf;
            status_bad_frame  <= drop_bad;
            status_good_frame <= commit;
            if (drop_ovf || drop_bad) wr_ptr_cur <= wr_ptr_commit;
            else if (mem_we)          wr_ptr_cur <= wr_ptr_cur + PTR_ONE;
            if (commit) wr_ptr_commit <= wr_ptr_cur + PTR_ONE;
        end
    end

    // Frame storage: {tuser, tlast, tdata} per entry
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_cur[AW-1:0]] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
    end

    // Registered RAM read; only committed entries are ever fetched
    always_ff @(posedge clk) begin
        if (rd_en) mem_rd_q <= mem[rd_ptr[AW-1:0]];
    end

    // Read pointer and read-stage valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            mem_rd_vld <= 1'b0;
        end else begin
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
            if (!mem_rd_vld || out_ready) mem_rd_vld <= rd_en;
        end
    end

    // Output register; holds its beat while the transmitter stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
        end else if (out_ready) begin
            m_axis_tvalid <= mem_rd_vld;
            if (mem_rd_vld) {m_axis_tuser, m_axis_tlast, m_axis_tdata} <= mem_rd_q;
        end
    end

`ifdef ETH_TX_SF_FRAME_COUNT_EN
    logic frame_out;
    assign frame_out = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    // Committed frames not yet fully read out; bumps the cycle after a commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_frame_count <= '0;
        end else begin
            case ({status_good_frame, frame_out})
                2'b10:   status_frame_count <= status_frame_count + PTR_ONE;
                2'b01:   status_frame_count <= status_frame_count - PTR_ONE;
                default: status_frame_count <= status_frame_count;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_eth_tx_sf_buffer.sv
// Scoreboard bench for eth_tx_sf_buffer. Stimulus pushes the bytes of every
// frame that should survive; a negedge monitor pops and compares each output
// handshake, checks stall stability and counts status pulses.
module tb_eth_tx_sf_buffer;

    localparam int DEPTH = 256;
    localparam int UW    = 2;
    localparam int AW    = $clog2(DEPTH);

    typedef struct packed {
        logic [7:0]    d;
        logic          l;
        logic [UW-1:0] u;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    s_tdata;
    logic          s_tvalid, s_tready, s_tlast;
    logic [UW-1:0] s_tuser;
    logic [7:0]    m_tdata;
    logic          m_tvalid, m_tready, m_tlast;
    logic [UW-1:0] m_tuser;
    logic          st_ovf, st_bad, st_good;
`ifdef ETH_TX_SF_FRAME_COUNT_EN
    logic [AW:0]   frame_count;
`endif

    eth_tx_sf_buffer #(
        .DEPTH(DEPTH), .DATA_WIDTH(8), .USER_WIDTH(UW), .DROP_BAD_FRAME(1)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .status_overflow(st_ovf), .status_bad_frame(st_bad), .status_good_frame(st_good)
`ifdef ETH_TX_SF_FRAME_COUNT_EN
        , .status_frame_count(frame_count)
`endif
    );

    always #5 clk = ~clk;

    beat_t exp_q[$];
    int    checks = 0, failures = 0;
    int    byte_ctr = 0;
    int    good_exp = 0, bad_exp = 0, ovf_exp = 0;
    int    good_seen = 0, bad_seen = 0, ovf_seen = 0;
    int    tlast_seen = 0, valid_cycles = 0;
    bit    tready_low_seen = 0;
    int    rdy_mode = 0;   // 0: always ready, 1: toggle, 2: random

    // Output ready pattern, changed just after each edge
    initial m_tready = 1'b1;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: scoreboard pop/compare, stall stability, pulse counting
    beat_t prev;
    bit    prev_hold = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 0;
        end else begin
            if (s_tvalid && !s_tready) tready_low_seen = 1;
            if (m_tvalid) valid_cycles++;
            if (prev_hold) begin
                checks++;
                if (!m_tvalid || {m_tdata, m_tlast, m_tuser} != prev) begin
                    failures++;
                    $display("FAIL stall_hold: got v=%0b %h/%0b/%h need v=1 %h/%0b/%h",
                             m_tvalid, m_tdata, m_tlast, m_tuser, prev.d, prev.l, prev.u);
                end
            end
            if (m_tvalid && m_tready) begin
                checks++;
                if (m_tlast) tlast_seen++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat: got %h/%0b/%h need no output",
                             m_tdata, m_tlast, m_tuser);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    if ({m_tdata, m_tlast, m_tuser} != e) begin
                        failures++;
                        $display("FAIL beat: got %h/%0b/%h need %h/%0b/%h",
                                 m_tdata, m_tlast, m_tuser, e.d, e.l, e.u);
                    end
                end
            end
            prev_hold = m_tvalid && !m_tready;
            prev      = '{d: m_tdata, l: m_tlast, u: m_tuser};
            if (st_good) good_seen++;
            if (st_bad)  bad_seen++;
            if (st_ovf)  ovf_seen++;
        end
    end

    task automatic check(input string name, input int got, input int need);
        checks++;
        if (got != need) begin
            failures++;
            $display("FAIL %s: got %0d need %0d", name, got, need);
        end
    endtask

    // One frame of counting-pattern bytes. Frames that fit wait until the
    // reference occupancy leaves room, so only oversize frames can overflow.
    task automatic send_frame(input int len, input bit bad, input bit gaps);
        bit oversize;
        int budget;
        oversize = (len > DEPTH);
        if (!oversize) begin
            budget = 0;
            while (exp_q.size() + len > DEPTH - 2 && budget < 4000) begin
                @(posedge clk); #1; budget++;
            end
            if (budget >= 4000) check("space_wait_timeout", budget, 0);
        end
        for (int i = 0; i < len; i++) begin
            beat_t b;
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    s_tvalid = 1'b0; @(posedge clk); #1;
                end
            end
            b.d = byte_ctr[7:0];
            b.l = (i == len - 1);
            b.u = {1'($urandom_range(0, 1)), (b.l && bad)};
            s_tdata = b.d; s_tlast = b.l; s_tuser = b.u; s_tvalid = 1'b1;
            if (!oversize && !bad) exp_q.push_back(b);
            @(posedge clk); #1;
            byte_ctr++;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = '0;
        if (oversize)  ovf_exp++;
        else if (bad)  bad_exp++;
        else           good_exp++;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < 20000) begin
            @(posedge clk); #1; n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int vc, tl0;
        rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tuser = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata_last_user", {m_tdata, m_tlast, m_tuser}, 0);
        check("rst_status", {st_ovf, st_bad, st_good}, 0);
`ifdef ETH_TX_SF_FRAME_COUNT_EN
        check("rst_frame_count", frame_count, 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        check("s_tready_after_rst", s_tready, 1);

        // 64-byte good frame: latency, contiguity, commit pulse
        byte_ctr = 0; rdy_mode = 0;
        send_frame(64, 0, 0);
        check("good_pulse", st_good, 1);
        check("tvalid_edge0", m_tvalid, 0);
        @(posedge clk); #1;
        check("tvalid_edge1", m_tvalid, 0);
        @(posedge clk); #1;
        check("tvalid_edge2", m_tvalid, 1);
        vc = 0;
        for (int i = 0; i < 64; i++) begin
            if (m_tvalid) vc++;
            @(posedge clk); #1;
        end
        check("contiguous_beats", vc, 64);
        check("tvalid_after_frame", m_tvalid, 0);
        wait_drain("drain_t1");

        // Bad frame dropped, then a good frame intact
        send_frame(60, 1, 0);
        check("bad_pulse", st_bad, 1);
        send_frame(64, 0, 0);
        wait_drain("drain_t2");

        // Oversize frame overflows; ready never drops; next frame intact
        send_frame(DEPTH + 44, 0, 0);
        send_frame(32, 0, 0);
        wait_drain("drain_t3");

        // Three back-to-back 64-byte frames with toggling ready
        rdy_mode = 1; tl0 = tlast_seen;
        for (int f = 0; f < 3; f++) send_frame(64, 0, 0);
        wait_drain("drain_t4");
        check("t4_tlast_beats", tlast_seen - tl0, 3);

        // Pointer wrap: many short frames, random gaps and back-pressure
        for (int f = 0; f < 200; f++) begin
            rdy_mode = $urandom_range(0, 2);
            send_frame(40, ($urandom_range(0, 7) == 0), 1);
        end
        send_frame(DEPTH + 1, 0, 1);
        rdy_mode = 0;
        wait_drain("drain_wrap");
`ifdef ETH_TX_SF_FRAME_COUNT_EN
        repeat (2) @(posedge clk);
        #1;
        check("frame_count_drained", frame_count, 0);
`endif

        // Reset while a frame streams out and another is half written
        rdy_mode = 0;
        send_frame(40, 0, 0);
        for (int i = 0; i < 10; i++) begin
            s_tdata = byte_ctr[7:0]; s_tlast = 1'b0; s_tuser = '0; s_tvalid = 1'b1;
            @(posedge clk); #1; byte_ctr++;
        end
        check("tvalid_before_rst", m_tvalid, 1);
        rst = 1'b1; s_tvalid = 1'b0;
        #1;
        check("tvalid_in_rst", m_tvalid, 0);
        check("s_tready_in_rst", s_tready, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        valid_cycles = 0;
        repeat (60) @(posedge clk);
        #1;
        check("no_output_after_rst", valid_cycles, 0);
`ifdef ETH_TX_SF_FRAME_COUNT_EN
        check("frame_count_after_rst", frame_count, 0);
`endif

        check("good_pulses", good_seen, good_exp);
        check("bad_pulses", bad_seen, bad_exp);
        check("ovf_pulses", ovf_seen, ovf_exp);
        check("s_tready_stayed_high", tready_low_seen, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
